seg7_scan_mux: RTL
==================

Name: seg7_scan_mux

Overview:
- Parametrised multiplexed 7-segment display driver.
- Successor to the fixed 4-digit selector: N digits, each with its own 4-bit hex value.
- Adds a per-digit blank mask, decimal points, leading-zero suppression, a dead-time between digits against ghosting, PWM brightness and frame-coherent input sampling.
- Sits between the irrigation counters/status logic and the board's common-anode display pins.

Parameters:
- N_DIGITS, 4: number of digits scanned (>=1).
- DIV, 50000: CLK cycles per digit slot (>=2).
- DEAD, 16: blank cycles at the start of each slot (0 <= DEAD < DIV).
- PWM_BITS, 4: brightness resolution.
- SEG_ACTIVE_LOW, 1: segment pin polarity (1 = 0 lights the segment).
- DIG_ACTIVE_LOW, 1: digit-select polarity (1 = 0 enables the digit).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  scan enable.
- DIGIT_VAL  in  4*N_DIGITS  hex value per digit; digit i = bits [4i+3:4i]; digit 0 is the rightmost/least significant.
- DIGIT_BLANK  in  N_DIGITS  1 = digit fully dark, including its DP.
- DP  in  N_DIGITS  decimal point request per digit.
- LZ_SUPPRESS  in  1  enables leading-zero suppression.
- BRIGHT  in  PWM_BITS  duty level; 0 = dark, all-ones = full.
- SEG  out  7  segments g..a (bit0 = a), polarity per SEG_ACTIVE_LOW.
- SEG_P  out  1  decimal point, same polarity as SEG.
- DIG  out  N_DIGITS  one-hot digit enable, polarity per DIG_ACTIVE_LOW.
- FRAME_TICK  out  1  one-cycle pulse at each frame start.

Behaviour:
- Reset (async, RST_N=0):
  - SEG, SEG_P and DIG take their "off" level immediately: with default parameters SEG=7'h7F, SEG_P=1, DIG=all ones.
  - FRAME_TICK=0; slot_cnt=0; idx=0; shadow registers cleared.
- Counters:
  - slot_cnt counts 0..DIV-1 while EN=1.
  - On wrap, idx advances modulo N_DIGITS; N_DIGITS-1 -> 0 starts a new frame.
- Frame start (idx=0, slot_cnt=0):
  - DIGIT_VAL, DIGIT_BLANK, DP, LZ_SUPPRESS and BRIGHT are copied into shadow registers.
  - FRAME_TICK is high for that cycle only.
  - All display decisions use shadow values only. Input changes mid-frame are never visible until the next frame.
- Leading-zero suppression (shadow LZ_SUPPRESS=1):
  - Digit i (i>0) is suppressed if the shadow values of digits N-1..i are all 0.
  - Digit 0 is never suppressed.
  - A suppressed digit shows no segments but still shows DP if requested.
- Digit light condition (digit idx): slot_cnt >= DEAD and pwm_on and not shadow DIGIT_BLANK[idx].
  - pwm_on = (BRIGHT == all-ones) or (slot_cnt[PWM_BITS-1:0] < BRIGHT), using shadow BRIGHT.
  - If the condition is false, DIG is all off and SEG/SEG_P are off.
- Decode: full hex table, active-high g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Output polarity is applied after decode.
- Latency: all outputs are registered, one cycle after the counter state that produced them. No combinational path from inputs to outputs.
- EN=0:
  - Next cycle: outputs go to the off level; slot_cnt=0, idx=0; FRAME_TICK=0.
  - First enabled cycle: a frame start occurs (shadow load plus FRAME_TICK).
- Never more than one DIG bit active.
- DIG is off during the DEAD window: when DEAD>=1 no two digits are ever lit on consecutive cycles across a slot boundary.
- N_DIGITS=1: idx stays 0 and every slot is a frame.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - SEG_OFF/DIG_OFF helper functions taking the polarity parameter;
  - the index-width function clog2(N_DIGITS).
- One combinational sub-module, seg7_hex_decode: 4-bit value in, 7-bit active-high segments out.
- Scanner, shadowing, suppression and PWM logic stay in the top module.

Test Plan:
All scenarios use N_DIGITS=4, DIV=8, DEAD=2, PWM_BITS=2, default polarities.
- Reset: RST_N=0 mid-slot -> same cycle SEG=7'h7F, SEG_P=1, DIG=4'hF. Release with EN=1 -> FRAME_TICK pulses every 32 cycles, exactly 1 cycle wide.
- Value display: DIGIT_VAL=16'h1234, BRIGHT=3, DP=4'b0010.
  - Digit 0 slot: DIG=4'b1110 for 6 of 8 cycles, SEG=7'b0011001 (4).
  - Digit 1 slot: SEG=7'b0110000 (3), SEG_P=0.
  - Cycles 0-1 of every slot: DIG=4'hF.
- Leading zeros, LZ_SUPPRESS=1:
  - 16'h0005: DIG bits 3..1 never low; digit 0 shows 7'b0010010.
  - 16'h0000: only digit 0 lit, showing 7'b1000000.
  - 16'h0105: digit 2 lit, digit 1 lit with 0.
- Brightness: BRIGHT=1 -> exactly 1 lit cycle per slot (slot_cnt=4). BRIGHT=2 -> 2 cycles. BRIGHT=0 -> DIG stays 4'hF for a full frame.
- Coherence and blanking:
  - Change DIGIT_VAL from 16'h1111 to 16'h2222 while idx=1 -> digits 2 and 3 still show 1 until after the next FRAME_TICK.
  - DIGIT_BLANK=4'b0100 -> digit 2 never enabled, DP[2]=1 ignored.
- Enable: drop EN mid-slot -> next cycle all outputs off. Raise EN -> FRAME_TICK on the first enabled cycle, and digit 0 scans first.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment driver.
// Segment order is g..a with bit0 = a, active-high before polarity.
package seg7_pkg;

  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Minimum width of 1 so single-digit builds still get a legal index
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic logic [6:0] seg_off(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

  function automatic logic [31:0] dig_off(input bit active_low);
    return active_low ? 32'hFFFF_FFFF : 32'h0;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to active-high g..a segment pattern.
// Pure combinational lookup into the package table.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[val];

endmodule

// File: rtl/seg7_scan_mux.sv
// N-digit multiplexed 7-segment scanner with dead-time, PWM dimming,
// leading-zero suppression and frame-coherent shadowing of all inputs.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int DIV            = 50000,
  parameter int DEAD           = 16,
  parameter int PWM_BITS       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  EN,
  input  logic [4*N_DIGITS-1:0] DIGIT_VAL,
  input  logic [N_DIGITS-1:0]   DIGIT_BLANK,
  input  logic [N_DIGITS-1:0]   DP,
  input  logic                  LZ_SUPPRESS,
  input  logic [PWM_BITS-1:0]   BRIGHT,
  output logic [6:0]            SEG,
  output logic                  SEG_P,
  output logic [N_DIGITS-1:0]   DIG,
  output logic                  FRAME_TICK
);

  localparam int IW = clog2(N_DIGITS);
  localparam int CW = clog2(DIV);
  localparam int VW = 4 * N_DIGITS;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF  = seg_off(SEG_ACTIVE_LOW);
  localparam logic [31:0]   DOFF32   = dig_off(DIG_ACTIVE_LOW);
  localparam logic [N_DIGITS-1:0] DIG_OFF = DOFF32[N_DIGITS-1:0];
  localparam logic          SEGP_OFF = SEG_ACTIVE_LOW;

  logic [CW-1:0]       slot_cnt;
  logic [IW-1:0]       idx;
  logic [VW-1:0]       sh_val;
  logic [N_DIGITS-1:0] sh_blank;
  logic [N_DIGITS-1:0] sh_dp;
  logic                sh_lz;
  logic [PWM_BITS-1:0] sh_bright;

  logic                frame_start;
  logic [VW-1:0]       e_val;
  logic [N_DIGITS-1:0] e_blank;
  logic [N_DIGITS-1:0] e_dp;
  logic                e_lz;
  logic [PWM_BITS-1:0] e_bright;
  logic [PWM_BITS-1:0] pwm_slot;

  logic [3:0]          cur_val;
  logic                cur_blank;
  logic                cur_dp;
  logic                supp;
  logic                dead_ok;
  logic                pwm_on;
  logic                lit;
  logic [6:0]          dec_seg;
  logic [6:0]          seg_raw;
  logic [N_DIGITS-1:0] dig_raw;

  assign frame_start = EN && (idx == '0) && (slot_cnt == '0);

  // The frame-start cycle already decides with the freshly sampled inputs
  assign e_val    = frame_start ? DIGIT_VAL   : sh_val;
  assign e_blank  = frame_start ? DIGIT_BLANK : sh_blank;
  assign e_dp     = frame_start ? DP          : sh_dp;
  assign e_lz     = frame_start ? LZ_SUPPRESS : sh_lz;
  assign e_bright = frame_start ? BRIGHT      : sh_bright;

  always_comb begin
    logic run;
    run       = e_lz;
    cur_val   = '0;
    cur_blank = 1'b0;
    cur_dp    = 1'b0;
    supp      = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      run = run && (e_val[4*i +: 4] == 4'h0);
      if (idx == IW'(i)) begin
        cur_val   = e_val[4*i +: 4];
        cur_blank = e_blank[i];
        cur_dp    = e_dp[i];
        supp      = run && (i > 0);
      end
    end
  end

  seg7_hex_decode u_dec (
    .val (cur_val),
    .seg (dec_seg)
  );

  assign pwm_slot = PWM_BITS'(slot_cnt);
  assign dead_ok  = int'(slot_cnt) >= DEAD;
  assign pwm_on   = (e_bright == '1) || (pwm_slot < e_bright);

  // A suppressed digit is only enabled when it has a DP to show
  assign lit = dead_ok && pwm_on && !cur_blank && !(supp && !cur_dp);

  assign seg_raw = (lit && !supp) ? dec_seg : 7'h00;

  always_comb begin
    dig_raw = '0;
    for (int i = 0; i < N_DIGITS; i++)
      dig_raw[i] = lit && (idx == IW'(i));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_cnt   <= '0;
      idx        <= '0;
      sh_val     <= '0;
      sh_blank   <= '0;
      sh_dp      <= '0;
      sh_lz      <= 1'b0;
      sh_bright  <= '0;
      SEG        <= SEG_OFF;
      SEG_P      <= SEGP_OFF;
      DIG        <= DIG_OFF;
      FRAME_TICK <= 1'b0;
    end else if (!EN) begin
      slot_cnt   <= '0;
      idx        <= '0;
      SEG        <= SEG_OFF;
      SEG_P      <= SEGP_OFF;
      DIG        <= DIG_OFF;
      FRAME_TICK <= 1'b0;
    end else begin
      if (slot_cnt == CNT_LAST) begin
        slot_cnt <= '0;
        idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        slot_cnt <= slot_cnt + 1'b1;
      end
      if (frame_start) begin
        sh_val    <= DIGIT_VAL;
        sh_blank  <= DIGIT_BLANK;
        sh_dp     <= DP;
        sh_lz     <= LZ_SUPPRESS;
        sh_bright <= BRIGHT;
      end
      FRAME_TICK <= frame_start;
      SEG        <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      SEG_P      <= SEG_ACTIVE_LOW ? ~(lit && cur_dp) : (lit && cur_dp);
      DIG        <= DIG_ACTIVE_LOW ? ~dig_raw : dig_raw;
    end
  end

endmodule
